rx_block_sync: RTL

Block-lock controller for the 10GBASE-R receive path. It monitors the 2-bit sync headers delivered by the GTX alongside each 64-bit block, and runs the block-lock hunt by pulsing the transceiver's RX slip. It declares block lock to the downstream 64b/66b decoder and XGMII logic. Optionally it also raises a high-BER flag from an invalid-header rate monitor.

---
 rtl/teng_phy_pkg.sv | 25 ++
 rtl/rx_block_sync_if.sv | 20 ++
 rtl/rx_ber_monitor.sv | 58 +++++
 rtl/rx_block_sync.sv | 124 ++++++++++++
 4 files changed

// File: rtl/teng_phy_pkg.sv
// Shared 10GBASE-R receive definitions: block-sync FSM encoding, sync-header codes,
// default window sizes and the header validity check.
package teng_phy_pkg;

  typedef logic [1:0] bsync_state_t;

  localparam logic [1:0] ST_HUNT      = 2'd0;
  localparam logic [1:0] ST_SLIP      = 2'd1;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd2;
  localparam logic [1:0] ST_LOCKED    = 2'd3;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b10;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b01;

  localparam int DEF_SH_CNT_MAX        = 64;
  localparam int DEF_SH_INVLD_MAX      = 16;
  localparam int DEF_SLIP_WAIT_CYCLES  = 32;
  localparam int DEF_BER_WINDOW_CYCLES = 39063;
  localparam int DEF_BER_INVLD_MAX     = 16;

  function automatic logic sync_hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_sync_if.sv
// Header/lock signal bundle between the GTX receive datapath and rx_block_sync.
// slave = block-sync side; master = the side presenting headers and consuming lock/slip.
interface rx_block_sync_if;
  logic [1:0]  decode_head_i;
  logic        decode_data_vld_i;
  logic        block_lock_o;
  logic        gt_rxslip_o;
  logic        hi_ber_o;
  logic [15:0] slip_cnt_o;

  modport slave (
    input  decode_head_i, decode_data_vld_i,
    output block_lock_o, gt_rxslip_o, hi_ber_o, slip_cnt_o
  );

  modport master (
    output decode_head_i, decode_data_vld_i,
    input  block_lock_o, gt_rxslip_o, hi_ber_o, slip_cnt_o
  );
endinterface

// File: rtl/rx_ber_monitor.sv
// Invalid-sync-header rate monitor: flags high BER when BER_INVLD_MAX bad headers land in one
// BER_WINDOW_CYCLES window while locked; 1-cycle registered output, everything held at 0 when unlocked.
module rx_ber_monitor
  import teng_phy_pkg::*;
#(
  parameter int BER_WINDOW_CYCLES = DEF_BER_WINDOW_CYCLES,
  parameter int BER_INVLD_MAX     = DEF_BER_INVLD_MAX
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  input  logic hdr_vld_i,
  input  logic hdr_invld_i,
  output logic hi_ber_o
);

  localparam int TMR_W = (BER_WINDOW_CYCLES > 1) ? $clog2(BER_WINDOW_CYCLES) : 1;
  localparam int CNT_W = $clog2(BER_INVLD_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BER_WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BER_INVLD_MAX);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hi_q, hi_d;

  always_comb begin
    cnt_inc = cnt_q;
    if (hdr_vld_i && hdr_invld_i && (cnt_q != CNT_MAX)) cnt_inc = cnt_q + CNT_W'(1);
    timer_d = '0;
    cnt_d   = '0;
    hi_d    = 1'b0;
    if (lock_i) begin
      // At the wrap the flag survives only if this window also reached the limit.
      if (timer_q == TMR_LAST) begin
        hi_d = (cnt_inc == CNT_MAX);
      end else begin
        timer_d = timer_q + TMR_W'(1);
        cnt_d   = cnt_inc;
        hi_d    = hi_q | (cnt_inc == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
      cnt_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
    end
  end

  assign hi_ber_o = hi_q;

endmodule

// File: rtl/rx_block_sync.sv
// 10GBASE-R block-lock FSM: hunts by pulsing GTX RX slip (slip 2 cycles after a bad header), declares lock.
// BER monitor is built only with RX_BLOCK_SYNC_BER_MON_EN defined; otherwise hi_ber_o is tied to 0.
module rx_block_sync
  import teng_phy_pkg::*;
#(
  parameter int SH_CNT_MAX        = DEF_SH_CNT_MAX,
  parameter int SH_INVLD_MAX      = DEF_SH_INVLD_MAX,
  parameter int SLIP_WAIT_CYCLES  = DEF_SLIP_WAIT_CYCLES,
  parameter int BER_WINDOW_CYCLES = DEF_BER_WINDOW_CYCLES,
  parameter int BER_INVLD_MAX     = DEF_BER_INVLD_MAX
) (
  input logic            clk_i,
  input logic            rst_i,
  rx_block_sync_if.slave sync_if
);

  localparam int WAIT_W = (SLIP_WAIT_CYCLES > 1) ? $clog2(SLIP_WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_CYCLES - 1);
  localparam logic [6:0]        SH_LAST   = 7'(SH_CNT_MAX);
  localparam logic [4:0]        INV_LAST  = 5'(SH_INVLD_MAX);

  bsync_state_t      state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d, sh_inc;
  logic [4:0]        invld_cnt_q, invld_cnt_d, invld_inc;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lock_q, slip_q;
  logic [15:0]       slip_cnt_q;
  logic              hdr_vld, hdr_ok, hi_ber;

  assign hdr_vld = sync_if.decode_data_vld_i;
  assign hdr_ok  = sync_hdr_valid(sync_if.decode_head_i);

  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    sh_inc      = sh_cnt_q + 7'd1;
    invld_inc   = invld_cnt_q + {4'd0, ~hdr_ok};
    case (state_q)
      ST_HUNT: begin
        if (hdr_vld) begin
          if (!hdr_ok) begin
            state_d = ST_SLIP;
          end else if (sh_inc == SH_LAST) begin
            state_d     = ST_LOCKED;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end
      ST_SLIP: begin
        state_d     = ST_SLIP_WAIT;
        sh_cnt_d    = '0;
        invld_cnt_d = '0;
        wait_cnt_d  = '0;
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_HUNT;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      ST_LOCKED: begin
        // Loss of lock takes priority when the window closes on the final bad header.
        if (hdr_vld) begin
          if (invld_inc == INV_LAST) begin
            state_d = ST_SLIP;
          end else if (sh_inc == SH_LAST) begin
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d    = sh_inc;
            invld_cnt_d = invld_inc;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      slip_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_q      <= (state_d == ST_LOCKED);
      slip_q      <= (state_q == ST_SLIP);
      if ((state_q == ST_SLIP) && (slip_cnt_q != 16'hFFFF)) slip_cnt_q <= slip_cnt_q + 16'd1;
    end
  end

`ifdef RX_BLOCK_SYNC_BER_MON_EN
  rx_ber_monitor #(
    .BER_WINDOW_CYCLES (BER_WINDOW_CYCLES),
    .BER_INVLD_MAX     (BER_INVLD_MAX)
  ) u_ber_monitor (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lock_i      (lock_q),
    .hdr_vld_i   (hdr_vld),
    .hdr_invld_i (~hdr_ok),
    .hi_ber_o    (hi_ber)
  );
`else
  // Constant 0; the BER parameters are referenced so both builds accept the same overrides.
  assign hi_ber = 1'b0 && (BER_WINDOW_CYCLES > 0) && (BER_INVLD_MAX > 0);
`endif

  assign sync_if.block_lock_o = lock_q;
  assign sync_if.gt_rxslip_o  = slip_q;
  assign sync_if.hi_ber_o     = hi_ber;
  assign sync_if.slip_cnt_o   = slip_cnt_q;

endmodule
